// File: rtl/bnn_pkg.sv
// Shared BNN definitions: top-level phase encoding, image/kernel sizes and the
// pixel loader state enum.
package bnn_pkg;

  typedef enum logic [2:0] {
    s_IDLE,
    s_LOAD,
    s_LAYER_1,
    s_LAYER_2,
    s_LAYER_3
  } state_t;

  typedef enum logic [2:0] {
    L_IDLE,
    L_PIX,
    L_WTS,
    L_CHK,
    L_DONE
  } loader_state_t;

  localparam int IMG_DIM   = 28;
  localparam int PIX_BYTES = 98;
  localparam int WT_BYTES  = 9;

endpackage

// File: rtl/pixel_loader_if.sv
// Byte-stream handshake into the pixel loader (valid/ready, one byte per beat).
interface pixel_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/pixel_loader.sv
// Loads a 28x28 binarised image (98 bytes, LSB first) and 9 kernel bytes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
//
// state  | meaning
// L_IDLE | waiting for state == s_LOAD, in_ready low
// L_PIX  | accepting pixel bytes 0..97
// L_WTS  | accepting weight bytes 0..8 (bit b = filter b)
// L_CHK  | accepting checksum byte (LOADER_CHECKSUM_EN only)
// L_DONE | image and weights complete, done high
import bnn_pkg::*;

module pixel_loader (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  state_t                                 state,
  pixel_loader_if.slave                          bus,
  output logic [IMG_DIM-1:0][IMG_DIM-1:0]        pixels,
  output logic [2:0][2:0][7:0]                   weights,
  output logic                                   done,
  output logic                                   err
);

  localparam logic [6:0] LAST_PIX = 7'(PIX_BYTES - 1);
  localparam logic [6:0] LAST_WT  = 7'(WT_BYTES - 1);

  loader_state_t                  fsm;
  logic [6:0]                     cnt;
  logic [PIX_BYTES-1:0][7:0]      pix_q;
  logic [WT_BYTES-1:0][7:0]       wt_q;
  logic                           xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_xor;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready = (fsm == L_PIX) || (fsm == L_WTS) || (fsm == L_CHK);
  assign xfer         = bus.in_valid && bus.in_ready;

  // Byte k bit b lands on linear pixel 8k+b, which is exactly the packed layout.
  assign pixels  = pix_q;
  assign weights = wt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= L_IDLE;
      cnt     <= '0;
      pix_q   <= '0;
      wt_q    <= '0;
      done    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_xor <= '0;
      err_q   <= 1'b0;
`endif
    end else if (state != s_LOAD) begin
      // Abort wins over any byte offered on this edge; arrays are retained.
      fsm   <= L_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (fsm)
        L_IDLE: begin
          fsm     <= L_PIX;
          cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
          chk_xor <= '0;
`endif
        end
        L_PIX: begin
          if (xfer) begin
            pix_q[cnt] <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
            chk_xor    <= chk_xor ^ bus.in_data;
`endif
            if (cnt == LAST_PIX) begin
              cnt <= '0;
              fsm <= L_WTS;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        L_WTS: begin
          if (xfer) begin
            wt_q[cnt[3:0]] <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
            chk_xor        <= chk_xor ^ bus.in_data;
`endif
            if (cnt == LAST_WT) begin
              cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
              fsm  <= L_CHK;
`else
              fsm  <= L_DONE;
              done <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        L_CHK: begin
          if (xfer) begin
            err_q <= (bus.in_data != chk_xor);
            done  <= 1'b1;
            fsm   <= L_DONE;
          end
        end
`endif
        L_DONE: begin
          fsm <= L_DONE;
        end
        default: begin
          fsm <= L_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_loader.sv
// Self-checking bench for pixel_loader: table-driven full loads, random loads
// against a byte-array model, plus abort, async reset and checksum sequences.
module tb_pixel_loader;
  import bnn_pkg::*;

  localparam int N_DATA = 107;
`ifdef LOADER_CHECKSUM_EN
  localparam int N_LOAD = 108;
`else
  localparam int N_LOAD = 107;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  state_t                 st;
  logic [27:0][27:0]      pixels;
  logic [2:0][2:0][7:0]   weights;
  logic                   done;
  logic                   err;

  pixel_loader_if bus();

  pixel_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .state   (st),
    .bus     (bus),
    .pixels  (pixels),
    .weights (weights),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  logic [7:0] stream [0:107];
  logic [7:0] mdl    [0:106];   // expected stored bytes: 0..97 pixels, 98..106 weights

  always @(posedge clk)
    if (rst_n && st == s_LOAD && bus.in_valid && bus.in_ready) n_acc <= n_acc + 1;

  typedef struct {
    logic [7:0] pix_b;
    logic [7:0] wt_b;
    int         bubble_pct;
    int         exp_ones;
    logic [7:0] exp_w;
  } vec_t;

  vec_t tbl [4];

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_arrays(input string nm);
    int bad;
    int fr, fc;
    logic ev;
    bad = 0; fr = -1; fc = -1;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        ev = mdl[(28*r + c) / 8][(28*r + c) % 8];
        if (pixels[r][c] !== ev) begin
          if (bad == 0) begin fr = r; fc = c; end
          bad++;
        end
      end
    for (int j = 0; j < 9; j++)
      if (weights[j/3][j%3] !== mdl[98 + j]) begin
        if (bad == 0) begin fr = 100 + j/3; fc = j%3; end
        bad++;
      end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bits/bytes differ (first at row %0d col %0d), expected 0 differences",
               nm, bad, fr, fc);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int bubble_pct,
                           output bit ok, output logic done_pre);
    int w, b;
    b = 0;
    while (b < 20 && int'($urandom_range(99)) < bubble_pct) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      b++;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    done_pre = done;
    ok       = bus.in_ready;
    @(posedge clk);
  endtask

  task automatic full_load(input int bubble_pct, input bit bad_chk);
    bit   ok;
    logic dpre;
    int   start;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < N_DATA; k++) x = x ^ stream[k];
    stream[N_DATA] = x ^ {7'b0, bad_chk};
`endif
    start = n_acc;
    dpre  = 1'b0;
    for (int k = 0; k < N_LOAD; k++) begin
      send_byte(stream[k], bubble_pct, ok, dpre);
      if (!ok) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: byte %0d not accepted, ready=0 expected ready=1", k);
        bus.in_valid = 1'b0;
        return;
      end
    end
    check_bit("done_before_last_edge", dpre, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_bit("done_after_last_byte", done, 1'b1);
    check_bit("ready_low_in_done", bus.in_ready, 1'b0);
    check_int("accepted_byte_count", n_acc - start, N_LOAD);
    for (int k = 0; k < N_DATA; k++) mdl[k] = stream[k];
    check_arrays("full_load_arrays");
`ifdef LOADER_CHECKSUM_EN
    check_bit("checksum_err", err, bad_chk);
`endif
  endtask

  task automatic leave_load();
    @(negedge clk);
    st = s_IDLE;
    repeat (2) @(negedge clk);
    check_bit("done_cleared_after_leave", done, 1'b0);
    check_bit("ready_low_in_idle", bus.in_ready, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    logic dpre;
    int   acc_before;

    tbl[0] = '{8'hFF, 8'hA5,  0, 784, 8'hA5};
    tbl[1] = '{8'hFF, 8'hA5, 40, 784, 8'hA5};
    tbl[2] = '{8'h0F, 8'h3C, 20, 392, 8'h3C};
    tbl[3] = '{8'h80, 8'h00,  0,  98, 8'h00};

    rst_n        = 1'b1;
    st           = s_IDLE;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int k = 0; k < N_DATA; k++) mdl[k] = 8'h00;

    #2 rst_n = 1'b0;
    #10;
    check_bit("reset_ready", bus.in_ready, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_err", err, 1'b0);
    check_arrays("reset_arrays");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("idle_ready_outside_load", bus.in_ready, 1'b0);

    // Table-driven full loads: constant pixel byte / weight byte patterns.
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      st = s_LOAD;
      for (int k = 0; k < 98; k++) stream[k] = tbl[t].pix_b;
      for (int k = 98; k < N_DATA; k++) stream[k] = tbl[t].wt_b;
      full_load(tbl[t].bubble_pct, 1'b0);
      check_int("table_pixel_ones", $countones(pixels), tbl[t].exp_ones);
      n_tests++;
      for (int j = 0; j < 9; j++)
        if (weights[j/3][j%3] !== tbl[t].exp_w) begin
          n_fail++;
          $display("FAIL table_weight: weights[%0d][%0d] got %h expected %h",
                   j/3, j%3, weights[j/3][j%3], tbl[t].exp_w);
          break;
        end
      repeat (3) @(negedge clk);
      check_bit("done_held_in_load", done, 1'b1);
      leave_load();
    end

    // Bit ordering: byte 3 bit 4 is linear pixel 28 = row 1 col 0.
    @(negedge clk);
    st = s_LOAD;
    for (int k = 0; k < 108; k++) stream[k] = 8'h00;
    stream[0] = 8'h01;
    stream[3] = 8'h10;
    full_load(0, 1'b0);
    check_bit("bitorder_p00", pixels[0][0], 1'b1);
    check_bit("bitorder_p10", pixels[1][0], 1'b1);
    check_int("bitorder_ones", $countones(pixels), 2);
    leave_load();

    // Random streams with random bubbles.
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      st = s_LOAD;
      for (int k = 0; k < N_DATA; k++) stream[k] = 8'($urandom);
      full_load(int'($urandom_range(60)), 1'b0);
      leave_load();
    end

    // Abort after 50 bytes; the byte offered on the abort edge must be dropped.
    @(negedge clk);
    st = s_LOAD;
    for (int k = 0; k < N_DATA; k++) stream[k] = 8'($urandom);
    for (int k = 0; k < 50; k++) begin
      send_byte(stream[k], 30, ok, dpre);
      if (!ok) begin
        n_tests++;
        n_fail++;
        $display("FAIL abort_handshake_timeout: byte %0d ready=0 expected ready=1", k);
        break;
      end
    end
    @(negedge clk);
    acc_before   = n_acc;
    st           = s_IDLE;
    bus.in_valid = 1'b1;
    bus.in_data  = ~mdl[50];
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_bit("abort_done", done, 1'b0);
    check_bit("abort_ready", bus.in_ready, 1'b0);
    check_int("abort_no_accept", n_acc - acc_before, 0);
    for (int k = 0; k < 50; k++) mdl[k] = stream[k];
    check_arrays("abort_retained_arrays");
    @(negedge clk);
    st = s_LOAD;
    for (int k = 0; k < N_DATA; k++) stream[k] = 8'($urandom);
    full_load(20, 1'b0);
    leave_load();

    // Asynchronous reset between edges at byte 60.
    @(negedge clk);
    st = s_LOAD;
    for (int k = 0; k < N_DATA; k++) stream[k] = 8'($urandom) | 8'h01;
    for (int k = 0; k < 60; k++) begin
      send_byte(stream[k], 0, ok, dpre);
      if (!ok) break;
    end
    #3 rst_n = 1'b0;
    #1;
    check_int("async_reset_pixels", $countones(pixels), 0);
    check_int("async_reset_weights", $countones(weights), 0);
    check_bit("async_reset_ready", bus.in_ready, 1'b0);
    check_bit("async_reset_done", done, 1'b0);
    acc_before = n_acc;
    @(negedge clk);
    check_int("reset_no_accept", n_acc - acc_before, 0);
    bus.in_valid = 1'b0;
    st           = s_IDLE;
    for (int k = 0; k < N_DATA; k++) mdl[k] = 8'h00;
    check_arrays("reset_cleared_arrays");
    rst_n = 1'b1;
    @(negedge clk);
    st = s_LOAD;
    for (int k = 0; k < N_DATA; k++) stream[k] = 8'($urandom);
    full_load(10, 1'b0);
    leave_load();

`ifdef LOADER_CHECKSUM_EN
    @(negedge clk);
    st = s_LOAD;
    for (int k = 0; k < N_DATA; k++) stream[k] = 8'($urandom);
    full_load(0, 1'b1);
    check_bit("bad_checksum_done", done, 1'b1);
    leave_load();
    check_bit("err_cleared_after_leave", err, 1'b0);
    @(negedge clk);
    st = s_LOAD;
    full_load(0, 1'b0);
    check_bit("good_checksum_done", done, 1'b1);
    leave_load();
`else
    check_bit("err_tied_low", err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_loader.md
PIXEL_LOADER -- requirements
Module: pixel_loader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port state, input, state_t (3), top-level phase; loader is active only while state == s_LOAD.
REQ-004 SHALL have port in_valid, input, 1, upstream byte valid.
REQ-005 SHALL have port in_data, input, 8, upstream byte.
REQ-006 SHALL have port in_ready, output, 1, loader accepts a byte this cycle.
REQ-007 SHALL have port pixels, output, [27:0][27:0] (784), binarised image for layer one.
REQ-008 SHALL have port weights, output, [2:0][2:0][7:0] (72), 3x3 kernel bits for 8 filters.
REQ-009 SHALL have port done, output, 1, image and weights complete.
REQ-010 SHALL have port err, output, 1, checksum mismatch; present only with LOADER_CHECKSUM_EN, otherwise tied 0.

Function
REQ-011 SHALL complete a byte transfer only on a clock edge where in_valid && in_ready are both high; no other byte is consumed.
REQ-012 SHALL implement FSM states L_IDLE, L_PIX, L_WTS, L_CHK (macro only), L_DONE.
REQ-013 SHALL move L_IDLE -> L_PIX on the first edge with state == s_LOAD.
REQ-014 SHALL assert in_ready combinationally in L_PIX, L_WTS and L_CHK, and deassert it in L_IDLE and L_DONE.
REQ-015 SHALL in L_PIX write pixel bit i = 8*k + b, for byte index k 0..97 and bit b 0..7 (LSB first), into pixels[i/28][i%28].
REQ-016 SHALL move L_PIX -> L_WTS on the transfer of byte 97, using a 7-bit byte counter that is cleared on the transition.
REQ-017 SHALL in L_WTS write byte j (0..8) into weights[j/3][j%3], with bit b belonging to filter b.
REQ-018 SHALL, on the transfer of weight byte 8, move L_WTS -> L_DONE, or L_WTS -> L_CHK with the macro defined.
REQ-019 SHALL assert done as a registered output exactly while in L_DONE, i.e. one cycle after the last accepted byte.
REQ-020 SHALL hold pixels and weights stable outside L_PIX and L_WTS.
REQ-021 SHALL move any state -> L_IDLE on the first edge with state != s_LOAD. This covers a mid-load abort: the counter is cleared, done is cleared, and partially written arrays are retained and not cleared.
REQ-022 SHALL, on re-entry to s_LOAD, restart from byte 0 and overwrite previous contents.
REQ-023 SHALL have the abort of REQ-021 take priority when a state change and a byte transfer fall on the same edge; the byte is discarded.
REQ-024 SHALL ignore in_data while in_valid is low, and SHALL allow bubbles of any length between bytes.

Reset
REQ-025 SHALL, while rst_n is low and independent of clk, force FSM = L_IDLE, counter = 0, pixels = 0, weights = 0, done = 0, err = 0.
REQ-026 SHALL have in_ready = 0 during reset.
REQ-027 SHALL, when reset is asserted mid-load, abandon the transfer, with no byte consumed on the following edge.

Configuration
REQ-028 SHALL, with LOADER_CHECKSUM_EN defined, keep a running XOR of all 107 data bytes and accept a 108th byte in L_CHK. It then enters L_DONE, with err = 1 if that byte does not equal the XOR and err = 0 otherwise; err is held until leaving L_DONE.
REQ-029 SHALL, without LOADER_CHECKSUM_EN, omit L_CHK and the XOR register, load exactly 107 bytes, and tie err to 0.

Structure
REQ-030 SHALL place state_t (s_IDLE..s_LAYER_3), IMG_DIM = 28, PIX_BYTES = 98, WT_BYTES = 9 and the loader FSM enum in shared package bnn_pkg, used by all layers.
REQ-031 SHALL be a single module with no sub-module; the counter and FSM are local.

Verification
REQ-032 SHALL cover a full load: state = s_LOAD, 98 pixel bytes 0xFF then 9 weight bytes 0xA5 with in_valid held high -> pixels all 1, each weights[r][c] = 8'hA5, done rises on the cycle after byte 106, and in_ready = 0 thereafter.
REQ-033 SHALL cover bit ordering: byte 0 = 0x01, byte 3 = 0x10, all others 0 -> only pixels[0][0] and pixels[1][0] set (linear index 28).
REQ-034 SHALL cover backpressure: in_valid toggled randomly with an identical byte stream -> final arrays identical to REQ-032, and the count of accepted bytes = 107.
REQ-035 SHALL cover abort: state leaves s_LOAD after 50 bytes, then returns -> done = 0, the loader restarts at byte 0, and a full reload gives correct arrays.
REQ-036 SHALL cover mid-load reset: rst_n pulsed low asynchronously (between clock edges) at byte 60 -> pixels = 0, weights = 0 and FSM = L_IDLE immediately, without waiting for a clock edge.
REQ-037 SHALL cover the checksum with the macro defined: a correct 108th byte -> err = 0 and done = 1; the same byte with bit 0 flipped -> err = 1 and done = 1.
